// File: rtl/em_reg.sv
// Execute-to-Memory pipeline register with exception merging, hold, flush and bubble control.
// Optional feature macro: EM_REG_EXC_EN (exception merging, faulting-op squash, FLUSH_PC load).
module em_reg #(
  parameter logic [31:0] FLUSH_PC = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  input  logic        req,
  input  logic        bubble,
  input  logic [31:0] E_PC,
  input  logic        E_BD,
  input  logic [31:0] E_ALURes,
  input  logic [31:0] E_RtData,
  input  logic [4:0]  E_RegAddr,
  input  logic        E_RegWrite,
  input  logic        E_IsLoad,
  input  logic        E_IsStore,
  input  logic        E_ExcValid,
  input  logic [4:0]  E_ExcCode,
  input  logic        E_ExcAriOv,
  input  logic        E_ExcDMOv,
  output logic [31:0] M_PC,
  output logic [31:0] M_ALURes,
  output logic [31:0] M_RtData,
  output logic [4:0]  M_RegAddr,
  output logic        M_RegWrite,
  output logic        M_IsLoad,
  output logic        M_IsStore,
  output logic        M_BD,
  output logic        M_ExcValid,
  output logic [4:0]  M_ExcCode,
  output logic        M_Valid
);

  localparam logic [4:0] ExcAdEL = 5'd4;
  localparam logic [4:0] ExcAdES = 5'd5;
  localparam logic [4:0] ExcOv   = 5'd12;

  typedef struct packed {
    logic [31:0] pc;
    logic        bd;
    logic [31:0] aluRes;
    logic [31:0] rtData;
    logic [4:0]  regAddr;
    logic        regWrite;
    logic        isLoad;
    logic        isStore;
    logic        excValid;
    logic [4:0]  excCode;
    logic        valid;
  } stage_t;

  stage_t      stageQ, stageD;
  logic        excValid;
  logic [4:0]  excCode;
  logic [31:0] flushPc;

`ifdef EM_REG_EXC_EN
  // Upstream exception outranks overflow; address overflow only counts for memory ops.
  always_comb begin
    excValid = 1'b1;
    excCode  = 5'd0;
    flushPc  = FLUSH_PC;
    if (E_ExcValid) begin
      excCode = E_ExcCode;
    end else if (E_ExcAriOv) begin
      excCode = ExcOv;
    end else if (E_ExcDMOv && E_IsLoad) begin
      excCode = ExcAdEL;
    end else if (E_ExcDMOv && E_IsStore) begin
      excCode = ExcAdES;
    end else begin
      excValid = 1'b0;
    end
  end
`else
  logic unused_exc;
  assign unused_exc = ^{E_ExcValid, E_ExcCode, E_ExcAriOv, E_ExcDMOv, FLUSH_PC,
                        ExcAdEL, ExcAdES, ExcOv};

  always_comb begin
    excValid = 1'b0;
    excCode  = 5'd0;
    flushPc  = 32'd0;
  end
`endif

  always_comb begin
    stageD = stageQ;
    if (req) begin
      stageD    = '0;
      stageD.pc = flushPc;
    end else if (en) begin
      if (bubble) begin
        stageD    = '0;
        stageD.pc = E_PC;
        stageD.bd = E_BD;
      end else begin
        stageD.pc       = E_PC;
        stageD.bd       = E_BD;
        stageD.aluRes   = E_ALURes;
        stageD.rtData   = E_RtData;
        stageD.regAddr  = E_RegAddr;
        stageD.regWrite = E_RegWrite & ~excValid;
        stageD.isLoad   = E_IsLoad & ~excValid;
        stageD.isStore  = E_IsStore & ~excValid;
        stageD.excValid = excValid;
        stageD.excCode  = excCode;
        stageD.valid    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stageQ <= '0;
    end else begin
      stageQ <= stageD;
    end
  end

  assign M_PC       = stageQ.pc;
  assign M_BD       = stageQ.bd;
  assign M_ALURes   = stageQ.aluRes;
  assign M_RtData   = stageQ.rtData;
  assign M_RegAddr  = stageQ.regAddr;
  assign M_RegWrite = stageQ.regWrite;
  assign M_IsLoad   = stageQ.isLoad;
  assign M_IsStore  = stageQ.isStore;
  assign M_ExcValid = stageQ.excValid;
  assign M_ExcCode  = stageQ.excCode;
  assign M_Valid    = stageQ.valid;

endmodule

// File: tb/tb_em_reg.sv
// Self-checking bench for em_reg: directed plan items plus randomized traffic vs. a reference model.
module tb_em_reg;

`ifdef EM_REG_EXC_EN
  localparam bit ExcEn = 1'b1;
`else
  localparam bit ExcEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n, en, req, bubble;
  logic [31:0] E_PC, E_ALURes, E_RtData;
  logic        E_BD, E_RegWrite, E_IsLoad, E_IsStore, E_ExcValid, E_ExcAriOv, E_ExcDMOv;
  logic [4:0]  E_RegAddr, E_ExcCode;
  logic [31:0] M_PC, M_ALURes, M_RtData;
  logic [4:0]  M_RegAddr, M_ExcCode;
  logic        M_RegWrite, M_IsLoad, M_IsStore, M_BD, M_ExcValid, M_Valid;

  int errs = 0;
  int checks = 0;

  // Expected M-stage contents, updated once per edge by the reference model.
  logic [31:0] xPc, xAlu, xRt;
  logic [4:0]  xAddr, xCode;
  logic        xWr, xLd, xSt, xBd, xExc, xVal;

  em_reg dut (
    .clk(clk), .reset_n(reset_n), .en(en), .req(req), .bubble(bubble),
    .E_PC(E_PC), .E_BD(E_BD), .E_ALURes(E_ALURes), .E_RtData(E_RtData),
    .E_RegAddr(E_RegAddr), .E_RegWrite(E_RegWrite), .E_IsLoad(E_IsLoad),
    .E_IsStore(E_IsStore), .E_ExcValid(E_ExcValid), .E_ExcCode(E_ExcCode),
    .E_ExcAriOv(E_ExcAriOv), .E_ExcDMOv(E_ExcDMOv),
    .M_PC(M_PC), .M_ALURes(M_ALURes), .M_RtData(M_RtData), .M_RegAddr(M_RegAddr),
    .M_RegWrite(M_RegWrite), .M_IsLoad(M_IsLoad), .M_IsStore(M_IsStore), .M_BD(M_BD),
    .M_ExcValid(M_ExcValid), .M_ExcCode(M_ExcCode), .M_Valid(M_Valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic clear_all(input logic [31:0] v);
    {xPc, xAlu, xRt, xAddr, xCode, xWr, xLd, xSt, xBd, xExc, xVal} = '0;
    xPc = v;
  endtask

  // Applies the per-edge rules in priority order to the current inputs.
  task automatic model_edge();
    bit          hasExc;
    logic [4:0]  code;
    if (!reset_n) begin
      clear_all(32'd0);
    end else if (req) begin
      clear_all(ExcEn ? 32'h0000_4180 : 32'd0);
    end else if (!en) begin
      // hold
    end else if (bubble) begin
      clear_all(E_PC);
      xBd = E_BD;
    end else begin
      hasExc = 1'b0;
      code   = 5'd0;
      if (ExcEn) begin
        if (E_ExcValid)                   begin hasExc = 1; code = E_ExcCode; end
        else if (E_ExcAriOv)              begin hasExc = 1; code = 5'd12; end
        else if (E_ExcDMOv && E_IsLoad)   begin hasExc = 1; code = 5'd4; end
        else if (E_ExcDMOv && E_IsStore)  begin hasExc = 1; code = 5'd5; end
      end
      xPc = E_PC; xBd = E_BD; xAlu = E_ALURes; xRt = E_RtData; xAddr = E_RegAddr;
      xWr = hasExc ? 1'b0 : E_RegWrite;
      xLd = hasExc ? 1'b0 : E_IsLoad;
      xSt = hasExc ? 1'b0 : E_IsStore;
      xExc = hasExc; xCode = code; xVal = 1'b1;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check("pc", M_PC, xPc);
    check("alu", M_ALURes, xAlu);
    check("rt", M_RtData, xRt);
    check("raddr", {27'd0, M_RegAddr}, {27'd0, xAddr});
    check("rwr", {31'd0, M_RegWrite}, {31'd0, xWr});
    check("ld", {31'd0, M_IsLoad}, {31'd0, xLd});
    check("st", {31'd0, M_IsStore}, {31'd0, xSt});
    check("bd", {31'd0, M_BD}, {31'd0, xBd});
    check("excv", {31'd0, M_ExcValid}, {31'd0, xExc});
    check("excc", {27'd0, M_ExcCode}, {27'd0, xCode});
    check("valid", {31'd0, M_Valid}, {31'd0, xVal});
  endtask

  task automatic zero_inputs();
    {E_PC, E_ALURes, E_RtData, E_BD, E_RegWrite, E_IsLoad, E_IsStore} = '0;
    {E_ExcValid, E_ExcAriOv, E_ExcDMOv, E_RegAddr, E_ExcCode} = '0;
    en = 1'b1; req = 1'b0; bubble = 1'b0;
  endtask

  initial begin
    logic [31:0] heldPc;
    zero_inputs();
    reset_n = 1'b0;
    {xPc, xAlu, xRt, xAddr, xCode, xWr, xLd, xSt, xBd, xExc, xVal} = '0;
    E_PC = 32'h3000; E_ALURes = 32'h1234;
    tick(); tick();
    check("rst_pc", M_PC, 32'd0);
    check("rst_valid", {31'd0, M_Valid}, 32'd0);

    reset_n = 1'b1;
    tick();
    check("ld_pc", M_PC, 32'h3000);
    check("ld_alu", M_ALURes, 32'h1234);
    check("ld_valid", {31'd0, M_Valid}, 32'd1);

    E_ExcAriOv = 1'b1; E_RegWrite = 1'b1; E_RegAddr = 5'd8;
    tick();
    check("ov_excv", {31'd0, M_ExcValid}, ExcEn ? 32'd1 : 32'd0);
    check("ov_code", {27'd0, M_ExcCode}, ExcEn ? 32'd12 : 32'd0);
    check("ov_rwr", {31'd0, M_RegWrite}, ExcEn ? 32'd0 : 32'd1);

    E_ExcAriOv = 1'b0; E_RegWrite = 1'b0; E_ExcDMOv = 1'b1; E_IsStore = 1'b1;
    tick();
    check("ades_code", {27'd0, M_ExcCode}, ExcEn ? 32'd5 : 32'd0);
    E_IsStore = 1'b0; E_IsLoad = 1'b1;
    tick();
    check("adel_code", {27'd0, M_ExcCode}, ExcEn ? 32'd4 : 32'd0);
    E_ExcValid = 1'b1; E_ExcCode = 5'd10;
    tick();
    check("up_code", {27'd0, M_ExcCode}, ExcEn ? 32'd10 : 32'd0);
    E_IsLoad = 1'b0; E_IsStore = 1'b0;
    tick();
    check("dmov_nomem", {31'd0, M_ExcValid}, ExcEn ? 32'd1 : 32'd0);

    zero_inputs();
    E_ExcDMOv = 1'b1;
    tick();
    check("dmov_ignored", {31'd0, M_ExcValid}, 32'd0);

    zero_inputs();
    E_PC = 32'h3004; E_ALURes = 32'hCAFE_0001; E_RegWrite = 1'b1;
    tick();
    heldPc = E_PC;
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      E_PC = $urandom; E_ALURes = $urandom; E_RegWrite = 1'($urandom);
      tick();
      check("hold_pc", M_PC, heldPc);
      check("hold_alu", M_ALURes, 32'hCAFE_0001);
    end
    req = 1'b1;
    tick();
    check("flush_pc", M_PC, ExcEn ? 32'h0000_4180 : 32'd0);
    check("flush_alu", M_ALURes, 32'd0);
    check("flush_valid", {31'd0, M_Valid}, 32'd0);

    zero_inputs();
    bubble = 1'b1; E_PC = 32'h3010; E_BD = 1'b1; E_RegWrite = 1'b1;
    tick();
    check("bub_pc", M_PC, 32'h3010);
    check("bub_bd", {31'd0, M_BD}, 32'd1);
    check("bub_rwr", {31'd0, M_RegWrite}, 32'd0);
    check("bub_valid", {31'd0, M_Valid}, 32'd0);

    req = 1'b1;
    tick();
    check("reqbub_pc", M_PC, ExcEn ? 32'h0000_4180 : 32'd0);
    check("reqbub_bd", {31'd0, M_BD}, 32'd0);
    reset_n = 1'b0;
    tick();
    check("rstreq_pc", M_PC, 32'd0);
    reset_n = 1'b1;

    for (int n = 0; n < 600; n++) begin
      reset_n    = ($urandom_range(0, 31) != 0);
      req        = ($urandom_range(0, 15) == 0);
      en         = ($urandom_range(0, 5) != 0);
      bubble     = ($urandom_range(0, 7) == 0);
      E_PC       = $urandom;
      E_ALURes   = $urandom;
      E_RtData   = $urandom;
      E_RegAddr  = 5'($urandom);
      E_BD       = 1'($urandom);
      E_RegWrite = 1'($urandom);
      E_IsLoad   = 1'($urandom);
      E_IsStore  = 1'($urandom);
      E_ExcValid = ($urandom_range(0, 3) == 0);
      E_ExcCode  = 5'($urandom);
      E_ExcAriOv = ($urandom_range(0, 3) == 0);
      E_ExcDMOv  = ($urandom_range(0, 2) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
